// File: rtl/rsaasip_pipe_pkg.sv
// Shared types and constants for the 16-bit pipe.
// Control-state encoding, register-file geometry, helpers.
package rsaasip_pipe_pkg;

  localparam int ARQ   = 16;
  localparam int NREGS = 16;
  localparam int RA_W  = $clog2(NREGS);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } ctrl_state_t;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic ifid_flush;
    logic idexe_bubble;
    logic issue;
  } seq_ctrl_t;

  function automatic logic [ARQ-1:0] sat_inc(
    input logic [ARQ-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// In-flight writer counters, one per register.
// Issue increments, WB retire decrements; lookups are combinational.
module reg_scoreboard
  import rsaasip_pipe_pkg::*;
#(
  parameter int NR       = NREGS,
  parameter int CNT_W    = 2,
  parameter bit ZERO_REG = 1'b1,
  localparam int AW      = $clog2(NR)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               inc_en,
  input  logic [AW-1:0]      inc_addr,
  input  logic               dec_en,
  input  logic [AW-1:0]      dec_addr,
  input  logic [2:0][AW-1:0] src_addr,
  input  logic [AW-1:0]      dst_addr,
  output logic [NR-1:0]      busy_vec,
  output logic [2:0]         src_busy,
  output logic               dst_full
);

  localparam logic [CNT_W-1:0] CMAX = '1;

  logic [CNT_W-1:0] cnt [NR];
  logic [NR-1:0]    up;
  logic [NR-1:0]    dn;

  // per-entry step; inc+dec on one reg cancel
  always_comb begin
    up = '0;
    dn = '0;
    for (int r = 0; r < NR; r++) begin
      logic iq;
      logic dq;
      iq = inc_en && (inc_addr == AW'(r))
         && !(ZERO_REG && (r == 0));
      dq = dec_en && (dec_addr == AW'(r));
      up[r] = iq && !dq && (cnt[r] != CMAX);
      dn[r] = dq && !iq && (cnt[r] != '0);
    end
  end

  // counter array
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NR; r++) cnt[r] <= '0;
    end else begin
      for (int r = 0; r < NR; r++) begin
        if (up[r])      cnt[r] <= cnt[r] + 1'b1;
        else if (dn[r]) cnt[r] <= cnt[r] - 1'b1;
      end
    end
  end

  // busy view and hazard lookups
  always_comb begin
    busy_vec = '0;
    src_busy = '0;
    for (int r = 0; r < NR; r++)
      busy_vec[r] = (cnt[r] != '0);
    for (int i = 0; i < 3; i++)
      src_busy[i] = (cnt[src_addr[i]] != '0)
                  && !(ZERO_REG && (src_addr[i] == '0));
    dst_full = (cnt[dst_addr] == CMAX)
             && !(ZERO_REG && (dst_addr == '0));
  end

endmodule

// File: rtl/id_hazard_ctrl.sv
// ID-stage sequencing: RAW/WAW stall, jump flush, bubbles.
// HAZ_PERF_CNT_EN adds saturating stall/flush counters.
module id_hazard_ctrl
  import rsaasip_pipe_pkg::*;
#(
  parameter int CNT_W     = 2,
  parameter int FLUSH_CYC = 2,
  parameter bit ZERO_REG  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [RA_W-1:0]  id_src1_addr,
  input  logic [RA_W-1:0]  id_src2_addr,
  input  logic [RA_W-1:0]  id_src3_addr,
  input  logic [2:0]       id_src_used,
  input  logic             id_wb_en,
  input  logic [RA_W-1:0]  id_dst_addr,
  input  logic             jtaken,
  input  logic             wb_wr_en,
  input  logic [RA_W-1:0]  wb_addr,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idexe_bubble,
  output logic             issue,
  output logic [1:0]       state,
  output logic [NREGS-1:0] busy_vec,
  output logic [ARQ-1:0]   stall_cnt,
  output logic [ARQ-1:0]   flush_cnt
);

  localparam int FC_W =
    (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
  localparam logic [FC_W-1:0] FC_LOAD =
    FC_W'(FLUSH_CYC - 1);

  ctrl_state_t     st_q;
  ctrl_state_t     st_d;
  logic [FC_W-1:0] fcnt_q;
  logic [FC_W-1:0] fcnt_d;
  logic [2:0]      src_busy;
  logic            dst_full;
  logic            hazard;
  seq_ctrl_t       ctl;

  reg_scoreboard #(
    .NR       (NREGS),
    .CNT_W    (CNT_W),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .inc_en   (ctl.issue & id_wb_en),
    .inc_addr (id_dst_addr),
    .dec_en   (wb_wr_en),
    .dec_addr (wb_addr),
    .src_addr ({id_src3_addr,
                id_src2_addr,
                id_src1_addr}),
    .dst_addr (id_dst_addr),
    .busy_vec (busy_vec),
    .src_busy (src_busy),
    .dst_full (dst_full)
  );

  assign hazard = id_valid
    & (|(src_busy & id_src_used)
       | (id_wb_en & dst_full));

  // state and flush-hold counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q   <= RUN;
      fcnt_q <= '0;
    end else begin
      st_q   <= st_d;
      fcnt_q <= fcnt_d;
    end
  end

  // next state and pipe enables; jump beats hazard
  always_comb begin
    st_d   = st_q;
    fcnt_d = fcnt_q;
    ctl    = '{pc_en:        1'b0,
               ifid_en:      1'b0,
               ifid_flush:   1'b0,
               idexe_bubble: 1'b1,
               issue:        1'b0};
    priority case (1'b1)
      !rst: ;
      jtaken: begin
        ctl.pc_en      = 1'b1;
        ctl.ifid_flush = 1'b1;
        st_d           = FLUSH;
        fcnt_d         = FC_LOAD;
      end
      st_q == FLUSH: begin
        ctl.pc_en      = 1'b1;
        ctl.ifid_flush = 1'b1;
        if (fcnt_q == '0) st_d = RUN;
        else fcnt_d = fcnt_q - 1'b1;
      end
      hazard: st_d = STALL;
      default: begin
        ctl.pc_en        = 1'b1;
        ctl.ifid_en      = 1'b1;
        ctl.idexe_bubble = 1'b0;
        ctl.issue        = id_valid;
        st_d             = RUN;
      end
    endcase
  end

  assign pc_en        = ctl.pc_en;
  assign ifid_en      = ctl.ifid_en;
  assign ifid_flush   = ctl.ifid_flush;
  assign idexe_bubble = ctl.idexe_bubble;
  assign issue        = ctl.issue;
  assign state        = st_q;

`ifdef HAZ_PERF_CNT_EN
  logic [ARQ-1:0] stall_q;
  logic [ARQ-1:0] flush_q;

  // saturating stall-cycle and jump counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (st_q == STALL) stall_q <= sat_inc(stall_q);
      if (jtaken)        flush_q <= sat_inc(flush_q);
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Bench for id_hazard_ctrl: directed scenarios plus
// random traffic against a pending-writer reference model.
module tb_id_hazard_ctrl;
  import rsaasip_pipe_pkg::*;

  localparam int NR   = 16;
  localparam int MAXW = 3;
  localparam int FCYC = 2;
`ifdef HAZ_PERF_CNT_EN
  localparam int PERF = 1;
`else
  localparam int PERF = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [3:0]  s1, s2, s3;
  logic [2:0]  used;
  logic        wb_en;
  logic [3:0]  dst;
  logic        jtaken;
  logic        wb_wr_en;
  logic [3:0]  wb_addr;
  logic        pc_en, ifid_en, ifid_flush;
  logic        idexe_bubble, issue;
  logic [1:0]  state;
  logic [15:0] busy_vec, stall_cnt, flush_cnt;

  always #5 clk = ~clk;

  id_hazard_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_src1_addr (s1),
    .id_src2_addr (s2),
    .id_src3_addr (s3),
    .id_src_used  (used),
    .id_wb_en     (wb_en),
    .id_dst_addr  (dst),
    .jtaken       (jtaken),
    .wb_wr_en     (wb_wr_en),
    .wb_addr      (wb_addr),
    .pc_en        (pc_en),
    .ifid_en      (ifid_en),
    .ifid_flush   (ifid_flush),
    .idexe_bubble (idexe_bubble),
    .issue        (issue),
    .state        (state),
    .busy_vec     (busy_vec),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  // reference model: pending writers per register
  int          m_cnt [NR];
  ctrl_state_t m_st = RUN;
  int          m_left;
  int          m_stalls;
  int          m_flushes;
  logic        e_pc, e_ifen, e_fl, e_bub, e_iss, m_haz;

  int passed = 0;
  int total  = 0;

  task automatic m_clear();
    for (int r = 0; r < NR; r++) m_cnt[r] = 0;
    m_st      = RUN;
    m_left    = 0;
    m_stalls  = 0;
    m_flushes = 0;
  endtask

  task automatic m_eval();
    bit fl;
    if (!rst) m_clear();
    m_haz = id_valid && (
      (used[0] && m_cnt[s1] > 0) ||
      (used[1] && m_cnt[s2] > 0) ||
      (used[2] && m_cnt[s3] > 0) ||
      (wb_en && m_cnt[dst] == MAXW));
    fl = (m_st == FLUSH) || jtaken;
    if (!rst) begin
      {e_pc, e_ifen, e_fl, e_bub, e_iss} = 5'b00010;
    end else begin
      e_pc  = fl || !m_haz;
      e_ifen = !fl && !m_haz;
      e_fl  = fl;
      e_bub = fl || m_haz;
      e_iss = !fl && id_valid && !m_haz;
    end
  endtask

  task automatic m_commit();
    bit inc, dec;
    if (!rst) begin
      m_clear();
      return;
    end
    if (m_st == STALL && m_stalls < 65535) m_stalls++;
    if (jtaken && m_flushes < 65535) m_flushes++;
    inc = e_iss && wb_en && dst != 0;
    dec = wb_wr_en;
    if (!(inc && dec && dst == wb_addr)) begin
      if (inc) m_cnt[dst]++;
      if (dec && m_cnt[wb_addr] > 0) m_cnt[wb_addr]--;
    end
    if (jtaken) begin
      m_st   = FLUSH;
      m_left = FCYC;
    end else if (m_st == FLUSH) begin
      m_left--;
      if (m_left == 0) m_st = RUN;
    end else begin
      m_st = m_haz ? STALL : RUN;
    end
  endtask

  function automatic logic [54:0] obs_v();
    return {pc_en, ifid_en, ifid_flush,
            idexe_bubble, issue, state,
            busy_vec, stall_cnt, flush_cnt};
  endfunction

  function automatic logic [54:0] exp_v();
    logic [15:0] b, sc, fc;
    for (int r = 0; r < NR; r++) b[r] = m_cnt[r] > 0;
    sc = (PERF != 0) ? 16'(m_stalls)  : 16'h0;
    fc = (PERF != 0) ? 16'(m_flushes) : 16'h0;
    return {e_pc, e_ifen, e_fl, e_bub, e_iss,
            2'(m_st), b, sc, fc};
  endfunction

  task automatic look();
    @(negedge clk);
    m_eval();
  endtask

  task automatic adv();
    m_commit();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    id_valid = 0; used = 0; wb_en = 0; jtaken = 0;
    wb_wr_en = 0; s1 = 0; s2 = 0; s3 = 0;
    dst = 0; wb_addr = 0;
  endtask

  task automatic set_instr(
    input logic v, input logic [3:0] a1,
    input logic [3:0] a2, input logic [3:0] a3,
    input logic [2:0] u, input logic w,
    input logic [3:0] d
  );
    id_valid = v; s1 = a1; s2 = a2; s3 = a3;
    used = u; wb_en = w; dst = d;
  endtask

  task automatic do_reset();
    rst = 0;
    set_idle();
    repeat (2) begin look(); adv(); end
    rst = 1;
  endtask

  task automatic test_reset();
    rst = 0;
    set_instr(1, 1, 2, 3, 3'b111, 1, 4);
    jtaken = 1; wb_wr_en = 1; wb_addr = 2;
    for (int i = 0; i < 3; i++) begin
      look();
      total++;
      if ({pc_en, idexe_bubble, issue, busy_vec}
          !== {1'b0, 1'b1, 1'b0, 16'h0})
        $display("FAIL reset_out c%0d: got pc%b bub%b iss%b busy%h want pc0 bub1 iss0 busy0000",
                 i, pc_en, idexe_bubble, issue, busy_vec);
      else passed++;
      total++;
      if (obs_v() !== exp_v())
        $display("FAIL reset_vec c%0d: got %h want %h",
                 i, obs_v(), exp_v());
      else passed++;
      adv();
    end
    rst = 1;
    set_idle();
    look();
    total++;
    if (state !== RUN || pc_en !== 1'b1)
      $display("FAIL reset_release: got st%0d pc%b want st0 pc1",
               state, pc_en);
    else passed++;
    adv();
  endtask

  task automatic test_raw_stall();
    do_reset();
    set_instr(1, 0, 0, 0, 3'b000, 1, 3);
    look();
    total++;
    if (obs_v() !== exp_v() || issue !== 1'b1)
      $display("FAIL raw_wr: got %h want %h",
               obs_v(), exp_v());
    else passed++;
    adv();
    set_instr(1, 3, 0, 0, 3'b001, 0, 0);
    for (int i = 0; i < 4; i++) begin
      look();
      total++;
      if (obs_v() !== exp_v() || issue !== 1'b0)
        $display("FAIL raw_stall c%0d: got %h want %h",
                 i, obs_v(), exp_v());
      else passed++;
      adv();
    end
    wb_wr_en = 1; wb_addr = 3;
    look();
    total++;
    if (obs_v() !== exp_v() || state !== STALL)
      $display("FAIL raw_wb: got %h want %h",
               obs_v(), exp_v());
    else passed++;
    adv();
    wb_wr_en = 0;
    look();
    total++;
    if (obs_v() !== exp_v() || issue !== 1'b1)
      $display("FAIL raw_release: got %h want %h",
               obs_v(), exp_v());
    else passed++;
    adv();
    set_idle();
    look();
    total++;
    if (stall_cnt !== 16'(PERF * 5) || state !== RUN)
      $display("FAIL raw_stall_cnt: got %0d st%0d want %0d st0",
               stall_cnt, state, PERF * 5);
    else passed++;
    adv();
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int r = 1; r <= 4; r++) begin
      set_instr(1, 4'(8 + r), 12, 0, 3'b011, 1, 4'(r));
      look();
      total++;
      if (obs_v() !== exp_v() || issue !== 1'b1)
        $display("FAIL b2b r%0d: got %h want %h",
                 r, obs_v(), exp_v());
      else passed++;
      adv();
    end
    set_idle();
    look();
    total++;
    if (busy_vec !== 16'h001E)
      $display("FAIL b2b_busy: got %h want 001e", busy_vec);
    else passed++;
    adv();
  endtask

  task automatic test_jump_flush();
    do_reset();
    set_instr(1, 0, 0, 0, 3'b000, 1, 3);
    look(); adv();
    set_instr(1, 3, 0, 0, 3'b001, 0, 0);
    look(); adv();
    look(); adv();
    jtaken = 1;
    look();
    total++;
    if (obs_v() !== exp_v() || state !== STALL
        || ifid_flush !== 1'b1 || issue !== 1'b0)
      $display("FAIL jmp_stall: got %h want %h",
               obs_v(), exp_v());
    else passed++;
    adv();
    jtaken = 0;
    set_instr(1, 9, 0, 0, 3'b001, 0, 0);
    for (int i = 0; i < 2; i++) begin
      look();
      total++;
      if (obs_v() !== exp_v() || state !== FLUSH
          || ifid_flush !== 1'b1 || issue !== 1'b0)
        $display("FAIL jmp_flush c%0d: got %h want %h",
                 i, obs_v(), exp_v());
      else passed++;
      adv();
    end
    look();
    total++;
    if (state !== RUN || issue !== 1'b1
        || flush_cnt !== 16'(PERF))
      $display("FAIL jmp_done: got st%0d iss%b fc%0d want st0 iss1 fc%0d",
               state, issue, flush_cnt, PERF);
    else passed++;
    adv();
  endtask

  task automatic test_same_cycle();
    do_reset();
    set_instr(1, 0, 0, 0, 3'b000, 1, 5);
    look(); adv();
    wb_wr_en = 1; wb_addr = 5;
    look();
    total++;
    if (obs_v() !== exp_v() || issue !== 1'b1)
      $display("FAIL same_iss: got %h want %h",
               obs_v(), exp_v());
    else passed++;
    adv();
    set_idle();
    look();
    total++;
    if (busy_vec !== 16'h0020)
      $display("FAIL same_hold: got %h want 0020", busy_vec);
    else passed++;
    adv();
    wb_wr_en = 1; wb_addr = 5;
    look(); adv();
    wb_addr = 7;
    look();
    total++;
    if (busy_vec !== 16'h0000)
      $display("FAIL same_retire: got %h want 0000", busy_vec);
    else passed++;
    adv();
    wb_wr_en = 0;
    set_instr(1, 7, 5, 0, 3'b011, 0, 0);
    look();
    total++;
    if (obs_v() !== exp_v() || busy_vec !== 16'h0
        || issue !== 1'b1)
      $display("FAIL same_idle: got %h want %h",
               obs_v(), exp_v());
    else passed++;
    adv();
  endtask

  task automatic test_zero_reg();
    do_reset();
    set_instr(1, 0, 0, 0, 3'b000, 1, 0);
    look(); adv();
    set_instr(1, 0, 0, 0, 3'b111, 1, 0);
    look();
    total++;
    if (issue !== 1'b1 || busy_vec[0] !== 1'b0
        || state !== RUN)
      $display("FAIL zero_reg: got iss%b b0%b st%0d want iss1 b00 st0",
               issue, busy_vec[0], state);
    else passed++;
    adv();
    set_idle();
    look();
    total++;
    if (obs_v() !== exp_v() || stall_cnt !== 16'h0)
      $display("FAIL zero_cnt: got %h want %h",
               obs_v(), exp_v());
    else passed++;
    adv();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 99) != 0);
      set_instr($urandom_range(0, 7) != 0,
                4'($urandom_range(0, 7)),
                4'($urandom_range(0, 7)),
                4'($urandom_range(0, 7)),
                3'($urandom),
                1'($urandom),
                4'($urandom_range(0, 7)));
      jtaken   = ($urandom_range(0, 15) == 0);
      wb_wr_en = ($urandom_range(0, 2) == 0);
      wb_addr  = 4'($urandom_range(0, 7));
      look();
      total++;
      if (obs_v() !== exp_v())
        $display("FAIL rand c%0d: got %h want %h",
                 i, obs_v(), exp_v());
      else passed++;
      adv();
    end
    rst = 1;
  endtask

  initial begin
    rst = 0;
    set_idle();
    test_reset();
    test_raw_stall();
    test_back_to_back();
    test_jump_flush();
    test_same_cycle();
    test_zero_reg();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
